// File: rtl/stopwatch_ctrl.sv
// Sequencer for the stopwatch digit chain: synchronises the buttons, runs the
// IDLE/RUN/PAUSE/DONE state machine, generates the count tick and stops at terminal count.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 1_000_000,
   parameter int CNT_W    = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ss,
   input  logic       btn_clr,
   input  logic       btn_plus2,
   input  logic       mode_down,
   input  logic       at_zero,
   input  logic       at_max,
   output logic       start,
   output logic       ups,
   output logic       force_reset,
   output logic       preset,
   output logic       plus_min2,
   output logic       done,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam int               BTN_SS   = 0;
   localparam int               BTN_CLR  = 1;
   localparam int               BTN_P2   = 2;
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

   logic [2:0]       btn_s1, btn_s2, btn_d, btn_rise;
   logic             mode_s1, mode_s2;

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] div_q, div_nxt;
   logic             ups_nxt;
   logic             preset_pend_q, preset_pend_nxt;
   logic             start_nxt, force_nxt, preset_nxt, plus_nxt;
   logic             tick, terminal;

   // Two-flop synchronisers, then a registered rise detector so every button
   // press becomes exactly one clean cycle seen by the FSM.
   // NOTE: sequential state uses non-blocking (<=) so all flops sample together.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1   <= '0;
         btn_s2   <= '0;
         btn_d    <= '0;
         btn_rise <= '0;
         mode_s1  <= 1'b0;
         mode_s2  <= 1'b0;
      end else begin
         btn_s1   <= {btn_plus2, btn_clr, btn_ss};
         btn_s2   <= btn_s1;
         btn_d    <= btn_s2;
         btn_rise <= btn_s2 & ~btn_d;
         mode_s1  <= mode_down;
         mode_s2  <= mode_s1;
      end
   end

   assign tick     = (div_q == DIV_LAST);
   assign terminal = ups ? at_max : at_zero;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latches.
      state_nxt       = state_q;
      div_nxt         = div_q;
      ups_nxt         = ups;
      preset_pend_nxt = 1'b0;
      start_nxt       = 1'b0;
      force_nxt       = 1'b0;
      preset_nxt      = 1'b0;
      plus_nxt        = 1'b0;

      case (state_q)
         IDLE: begin
            div_nxt = '0;
            if (btn_rise[BTN_CLR])     force_nxt = 1'b1;
            else if (btn_rise[BTN_SS]) state_nxt = RUN;
            else if (btn_rise[BTN_P2]) plus_nxt  = 1'b1;
            // Direction switch disagrees with ups: flip it now, load presets next edge.
            if (mode_s2 == ups) begin
               ups_nxt         = ~mode_s2;
               preset_pend_nxt = 1'b1;
            end
         end
         RUN: begin
            if (btn_rise[BTN_CLR]) begin
               state_nxt = IDLE;
               force_nxt = 1'b1;
               div_nxt   = '0;
            end else if (btn_rise[BTN_SS]) begin
               state_nxt = PAUSE;
            end else if (tick) begin
               div_nxt = '0;
               if (terminal) state_nxt = DONE;
               else          start_nxt = 1'b1;
            end else begin
               div_nxt = div_q + CNT_W'(1);
            end
         end
         PAUSE: begin
            if (btn_rise[BTN_CLR]) begin
               state_nxt = IDLE;
               force_nxt = 1'b1;
            end else if (btn_rise[BTN_SS]) begin
               state_nxt = RUN;
            end else if (btn_rise[BTN_P2]) begin
               plus_nxt = 1'b1;
            end
         end
         DONE: begin
            div_nxt = '0;
            if (btn_rise[BTN_CLR]) begin
               state_nxt = IDLE;
               force_nxt = 1'b1;
            end else if (btn_rise[BTN_SS]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A pending preset yields to a clear or tick in the same cycle and fires one cycle later.
      if (preset_pend_q) begin
         if (force_nxt || start_nxt) preset_pend_nxt = 1'b1;
         else                        preset_nxt      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         div_q         <= '0;
         ups           <= 1'b1;
         preset_pend_q <= 1'b0;
         start         <= 1'b0;
         force_reset   <= 1'b0;
         preset        <= 1'b0;
         plus_min2     <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         div_q         <= div_nxt;
         ups           <= ups_nxt;
         preset_pend_q <= preset_pend_nxt;
         start         <= start_nxt;
         force_reset   <= force_nxt;
         preset        <= preset_nxt;
         plus_min2     <= plus_nxt;
      end
   end

   assign state = state_q;
   assign done  = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (TICK_DIV=4): stimulus pushes hand-timed expected
// output events; a negedge monitor pops one per observed event and compares it.
module tb_stopwatch_ctrl;

   localparam int         TICK_DIV = 4;
   localparam int         CNT_W    = 3;
   localparam logic [2:0] SS       = 3'b001;
   localparam logic [2:0] CLR      = 3'b010;
   localparam logic [2:0] P2       = 3'b100;
   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_RUN    = 2'b01;
   localparam logic [1:0] S_PAUSE  = 2'b10;
   localparam logic [1:0] S_DONE   = 2'b11;

   // One output event: any pulse high, or a change of state/ups/done.
   typedef struct packed {
      int         cyc;
      logic [1:0] st;
      logic       ups;
      logic       done;
      logic       start;
      logic       force_reset;
      logic       preset;
      logic       plus_min2;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset, btn_ss, btn_clr, btn_plus2, mode_down, at_zero, at_max;
   logic       start, ups, force_reset, preset, plus_min2, done;
   logic [1:0] state;

   int         cyc      = 0;
   int         n_checks = 0;
   int         n_pass   = 0;
   bit         mon_en   = 1'b0;
   ev_t        exp_q[$];
   logic [1:0] prev_st;
   logic       prev_ups, prev_done;

   stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_ss      (btn_ss),
      .btn_clr     (btn_clr),
      .btn_plus2   (btn_plus2),
      .mode_down   (mode_down),
      .at_zero     (at_zero),
      .at_max      (at_max),
      .start       (start),
      .ups         (ups),
      .force_reset (force_reset),
      .preset      (preset),
      .plus_min2   (plus_min2),
      .done        (done),
      .state       (state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Argument order: cycle, state, ups, done, start, force_reset, preset, plus_min2.
   function automatic ev_t mk_ev(input int c, input logic [1:0] st, input logic u, input logic d,
                                 input logic s, input logic f, input logic p, input logic pl);
      ev_t e;
      e.cyc = c; e.st = st; e.ups = u; e.done = d;
      e.start = s; e.force_reset = f; e.preset = p; e.plus_min2 = pl;
      return e;
   endfunction

   function automatic string ev_str(input ev_t e);
      return $sformatf("cyc=%0d state=%b ups=%b done=%b start=%b force_reset=%b preset=%b plus_min2=%b",
                       e.cyc, e.st, e.ups, e.done, e.start, e.force_reset, e.preset, e.plus_min2);
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
   endtask

   task automatic check_ev(input ev_t got, input ev_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL event: got {%s}, expected {%s}", ev_str(got), ev_str(exp));
   endtask

   task automatic note_unexpected(input ev_t got);
      n_checks++;
      $display("FAIL unexpected_event: got {%s}, expected none", ev_str(got));
   endtask

   task automatic note_missing(input ev_t exp);
      n_checks++;
      $display("FAIL missing_event: got none, expected {%s}", ev_str(exp));
   endtask

   // Monitor: samples on the falling edge, pops and compares one expectation per event.
   always @(negedge clk) begin
      if (mon_en && (start || force_reset || preset || plus_min2 ||
                     state !== prev_st || ups !== prev_ups || done !== prev_done)) begin
         if (exp_q.size() == 0)
            note_unexpected(mk_ev(cyc, state, ups, done, start, force_reset, preset, plus_min2));
         else
            check_ev(mk_ev(cyc, state, ups, done, start, force_reset, preset, plus_min2),
                     exp_q.pop_front());
      end
      prev_st   <= state;
      prev_ups  <= ups;
      prev_done <= done;
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Button level held for two cycles; a press starting at cycle N acts on edge N+4.
   task automatic press(input logic [2:0] m);
      {btn_plus2, btn_clr, btn_ss} = m;
      repeat (2) @(negedge clk);
      {btn_plus2, btn_clr, btn_ss} = 3'b000;
   endtask

   initial begin
      #50000;
      $display("FAIL timeout: got no end of stimulus, expected finish within 50000 ns");
      $fatal(1, "timeout");
   end

   initial begin
      int e, a, b, c, d, f, g;
      reset = 1'b1; btn_ss = 1'b0; btn_clr = 1'b0; btn_plus2 = 1'b0;
      mode_down = 1'b0; at_zero = 1'b0; at_max = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      check("reset_state",       64'(state),       64'(S_IDLE));
      check("reset_ups",         64'(ups),         64'(1));
      check("reset_done",        64'(done),        64'(0));
      check("reset_start",       64'(start),       64'(0));
      check("reset_force_reset", 64'(force_reset), 64'(0));
      check("reset_preset",      64'(preset),      64'(0));
      check("reset_plus_min2",   64'(plus_min2),   64'(0));
      mon_en = 1'b1;

      // Count up into at_max: DONE on the first tick; plus2 ignored in DONE; ss returns to IDLE.
      at_max = 1'b1;
      e = cyc;
      exp_q.push_back(mk_ev(e + 4,  S_RUN,  1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(e + 8,  S_DONE, 1, 1, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(e + 15, S_IDLE, 1, 0, 0, 0, 0, 0));
      press(SS);
      wait_until(e + 9);
      press(P2);
      press(SS);
      wait_until(e + 16);
      at_max = 1'b0;

      // Run, pause mid-period with divider at 1, resume, plus2 ignored, then clr+ss together.
      a = cyc;
      exp_q.push_back(mk_ev(a + 4,  S_RUN,   1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 8,  S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 12, S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 16, S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 20, S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 22, S_PAUSE, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 32, S_RUN,   1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 35, S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 39, S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(a + 41, S_IDLE,  1, 0, 0, 1, 0, 0));
      press(SS);
      wait_until(a + 18);
      press(SS);
      wait_until(a + 28);
      press(SS);
      press(P2);
      wait_until(a + 37);
      press(SS | CLR);
      wait_until(a + 44);

      // plus2 in IDLE.
      b = cyc;
      exp_q.push_back(mk_ev(b + 4, S_IDLE, 1, 0, 0, 0, 0, 1));
      press(P2);
      wait_until(b + 6);

      // Switch to count-down: ups flips, preset follows; at_zero ends the run; clr from DONE.
      c = cyc;
      mode_down = 1'b1;
      at_zero   = 1'b1;
      exp_q.push_back(mk_ev(c + 3, S_IDLE, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(c + 4, S_IDLE, 0, 0, 0, 0, 1, 0));
      wait_until(c + 6);
      d = cyc;
      exp_q.push_back(mk_ev(d + 4,  S_RUN,  0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(d + 8,  S_DONE, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(d + 14, S_IDLE, 0, 0, 0, 1, 0, 0));
      press(SS);
      wait_until(d + 10);
      press(CLR);
      wait_until(d + 16);
      at_zero = 1'b0;

      // Back to count-up.
      f = cyc;
      mode_down = 1'b0;
      exp_q.push_back(mk_ev(f + 3, S_IDLE, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(f + 4, S_IDLE, 1, 0, 0, 0, 1, 0));
      wait_until(f + 6);

      // Pause on a period boundary, plus2 in PAUSE, resume, then reset mid-RUN.
      g = cyc;
      exp_q.push_back(mk_ev(g + 4,  S_RUN,   1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(g + 8,  S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(g + 12, S_RUN,   1, 0, 1, 0, 0, 0));
      exp_q.push_back(mk_ev(g + 13, S_PAUSE, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(g + 18, S_PAUSE, 1, 0, 0, 0, 0, 1));
      exp_q.push_back(mk_ev(g + 23, S_RUN,   1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk_ev(g + 26, S_IDLE,  1, 0, 0, 0, 0, 0));
      press(SS);
      wait_until(g + 9);
      press(SS);
      wait_until(g + 14);
      press(P2);
      wait_until(g + 19);
      press(SS);
      wait_until(g + 25);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_until(g + 34);

      while (exp_q.size() > 0) note_missing(exp_q.pop_front());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
